// File: rtl/not_gate_pkg.sv
// Shared constants and helpers for the not_gate_pipe inverter family.
//   TOGGLE_CNT_W : width of the optional output toggle counter
//   MAX_LATENCY  : largest supported pipeline depth
//   MAX_FILL_W   : largest data width all_ones() can produce
//   all_ones()   : reset-fill pattern, i.e. the inverse of an all-zero input
package not_gate_pkg;

  localparam int unsigned TOGGLE_CNT_W = 16;
  localparam int unsigned MAX_LATENCY  = 8;
  localparam int unsigned MAX_FILL_W   = 256;

  // Low `width` bits set; callers truncate to their own width.
  function automatic logic [MAX_FILL_W-1:0] all_ones(input int unsigned width);
    logic [MAX_FILL_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_FILL_W; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/not_gate_pipe_if.sv
// Data/valid bundle for not_gate_pipe.
//   en        : pipeline advance enable (master -> slave)
//   a/a_valid : input word and qualifier (master -> slave)
//   y/y_valid : inverted word and qualifier (slave -> master)
interface not_gate_pipe_if #(
  parameter int unsigned WIDTH = 1
) ();

  logic             en;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (output en, a, a_valid, input y, y_valid);
  modport slave  (input en, a, a_valid, output y, y_valid);

endinterface

// File: rtl/not_gate_stage.sv
// One pipeline stage of not_gate_pipe: data register plus valid bit.
//   clk, rst  : rising-edge clock, synchronous active-high reset (fills data with ones)
//   en        : advance enable; low holds both registers
//   d/d_valid : next-stage input
//   q/q_valid : registered output
module not_gate_stage
  import not_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  localparam logic [WIDTH-1:0] FILL = WIDTH'(all_ones(WIDTH));

  // Reset outranks enable; data is captured regardless of d_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= FILL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/not_gate_pipe.sv
// Bitwise inverter y = ~a with a LATENCY-deep pipeline and travelling valid.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset (data -> all ones, valid -> 0)
//   bus        : not_gate_pipe_if.slave (en, a, a_valid in; y, y_valid out)
//   toggle_cnt : saturating count of final-stage value changes, only when
//                NOT_GATE_TOGGLE_CNT_EN is defined
// LATENCY = 0 gives a purely combinational path; rst/en then do not affect y.
module not_gate_pipe
  import not_gate_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned LATENCY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef NOT_GATE_TOGGLE_CNT_EN
  output logic [TOGGLE_CNT_W-1:0] toggle_cnt,
`endif
  not_gate_pipe_if.slave          bus
);

  if (LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("not_gate_pipe: LATENCY out of range");
  end
  if (WIDTH < 1 || WIDTH > MAX_FILL_W) begin : g_bad_width
    $error("not_gate_pipe: WIDTH out of range");
  end

`ifdef NOT_GATE_TOGGLE_CNT_EN
  logic toggle_hit_c;
`endif

  if (LATENCY == 0) begin : g_comb
    assign bus.y       = ~bus.a;
    assign bus.y_valid = bus.a_valid;

    // Enable never matters for the combinational path.
    logic unused_en;
    assign unused_en = bus.en;

`ifdef NOT_GATE_TOGGLE_CNT_EN
    // Shadow of ~a from the previous edge, to detect output changes.
    logic [WIDTH-1:0] shadow;
    always_ff @(posedge clk) begin
      if (rst) shadow <= WIDTH'(all_ones(WIDTH));
      else     shadow <= ~bus.a;
    end
    assign toggle_hit_c = (~bus.a != shadow);
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [LATENCY];
    logic             stage_v [LATENCY];

    // Inversion happens once, ahead of stage 0; later stages just shift.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      logic [WIDTH-1:0] d;
      logic             dv;
      if (k == 0) begin : g_head
        assign d  = ~bus.a;
        assign dv = bus.a_valid;
      end else begin : g_link
        assign d  = stage_q[k-1];
        assign dv = stage_v[k-1];
      end
      not_gate_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .d       (d),
        .d_valid (dv),
        .q       (stage_q[k]),
        .q_valid (stage_v[k])
      );
    end

    assign bus.y       = stage_q[LATENCY-1];
    assign bus.y_valid = stage_v[LATENCY-1];

`ifdef NOT_GATE_TOGGLE_CNT_EN
    // Value about to be loaded into the final stage.
    logic [WIDTH-1:0] final_load;
    if (LATENCY == 1) begin : g_load_in
      assign final_load = ~bus.a;
    end else begin : g_load_stage
      assign final_load = stage_q[LATENCY-2];
    end
    assign toggle_hit_c = bus.en && (final_load != stage_q[LATENCY-1]);
`endif
  end

`ifdef NOT_GATE_TOGGLE_CNT_EN
  // Saturating change counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt <= '0;
    end else if (toggle_hit_c && (toggle_cnt != '1)) begin
      toggle_cnt <= toggle_cnt + TOGGLE_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_not_gate_pipe.sv
// Directed bench for not_gate_pipe across several WIDTH/LATENCY builds.
// Toggle-counter checks run only when NOT_GATE_TOGGLE_CNT_EN is defined.
module tb_not_gate_pipe;
  import not_gate_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst0, rst2, rst3, rsts;

  not_gate_pipe_if #(.WIDTH(3)) if0 ();
  not_gate_pipe_if #(.WIDTH(3)) if2 ();
  not_gate_pipe_if #(.WIDTH(4)) if3 ();
  not_gate_pipe_if #(.WIDTH(4)) ifs ();

`ifdef NOT_GATE_TOGGLE_CNT_EN
  logic [TOGGLE_CNT_W-1:0] tc0, tc2, tc3, tcs, tct;
  logic rstt;
  not_gate_pipe_if #(.WIDTH(1)) ift ();
  not_gate_pipe #(.WIDTH(1), .LATENCY(1)) u_t (.clk(clk), .rst(rstt), .toggle_cnt(tct), .bus(ift));
`endif

  not_gate_pipe #(.WIDTH(3), .LATENCY(0)) u_0 (
    .clk(clk), .rst(rst0),
`ifdef NOT_GATE_TOGGLE_CNT_EN
    .toggle_cnt(tc0),
`endif
    .bus(if0));
  not_gate_pipe #(.WIDTH(3), .LATENCY(2)) u_2 (
    .clk(clk), .rst(rst2),
`ifdef NOT_GATE_TOGGLE_CNT_EN
    .toggle_cnt(tc2),
`endif
    .bus(if2));
  not_gate_pipe #(.WIDTH(4), .LATENCY(3)) u_3 (
    .clk(clk), .rst(rst3),
`ifdef NOT_GATE_TOGGLE_CNT_EN
    .toggle_cnt(tc3),
`endif
    .bus(if3));
  not_gate_pipe #(.WIDTH(4), .LATENCY(2)) u_s (
    .clk(clk), .rst(rsts),
`ifdef NOT_GATE_TOGGLE_CNT_EN
    .toggle_cnt(tcs),
`endif
    .bus(ifs));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] stream_in  [4];
  logic [3:0] stream_exp [4];

  initial begin
    stream_in  = '{4'h0, 4'h5, 4'hA, 4'hF};
    stream_exp = '{4'hF, 4'hA, 4'h5, 4'h0};

    {rst0, rst2, rst3, rsts} = 4'b1111;
    if0.en = 1'b1; if0.a = '0; if0.a_valid = 1'b0;
    if2.en = 1'b1; if2.a = '0; if2.a_valid = 1'b0;
    if3.en = 1'b1; if3.a = '0; if3.a_valid = 1'b0;
    ifs.en = 1'b1; ifs.a = '0; ifs.a_valid = 1'b0;
`ifdef NOT_GATE_TOGGLE_CNT_EN
    rstt = 1'b1; ift.en = 1'b1; ift.a = '0; ift.a_valid = 1'b0;
`endif
    tick();
    tick();
    check("rst_y_l2", 32'(if2.y), 32'h7);
    check("rst_v_l2", 32'(if2.y_valid), 32'h0);
    check("rst_y_l3", 32'(if3.y), 32'hF);
    check("rst_v_l3", 32'(if3.y_valid), 32'h0);
    {rst0, rst2, rst3, rsts} = 4'b0000;

    // LATENCY=0: combinational, rst/en have no effect
    if0.a = 3'b000; if0.a_valid = 1'b0; #1;
    check("l0_y_000", 32'(if0.y), 32'h7);
    check("l0_v_0", 32'(if0.y_valid), 32'h0);
    if0.a = 3'b101; if0.a_valid = 1'b1; #1;
    check("l0_y_101", 32'(if0.y), 32'h2);
    check("l0_v_1", 32'(if0.y_valid), 32'h1);
    rst0 = 1'b1; if0.en = 1'b0;
    tick();
    check("l0_y_rst", 32'(if0.y), 32'h2);
    check("l0_v_rst", 32'(if0.y_valid), 32'h1);
    rst0 = 1'b0; if0.en = 1'b1;

    // LATENCY=2: single valid word, exactly two edges of delay
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check("l2_rst_y", 32'(if2.y), 32'h7);
    check("l2_rst_v", 32'(if2.y_valid), 32'h0);
    if2.a = 3'b011; if2.a_valid = 1'b1;
    tick();
    if2.a = 3'b000; if2.a_valid = 1'b0;
    check("l2_e1_v", 32'(if2.y_valid), 32'h0);
    tick();
    check("l2_e2_y", 32'(if2.y), 32'h4);
    check("l2_e2_v", 32'(if2.y_valid), 32'h1);
    tick();
    check("l2_e3_v", 32'(if2.y_valid), 32'h0);
    check("l2_e3_y", 32'(if2.y), 32'h7);

    // LATENCY=3: back-to-back stream, no gaps
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        if3.a = stream_in[i]; if3.a_valid = 1'b1;
      end else begin
        if3.a = 4'h0; if3.a_valid = 1'b0;
      end
      tick();
      if (i >= 2 && i <= 5) begin
        check("l3_stream_y", 32'(if3.y), 32'(stream_exp[i-2]));
        check("l3_stream_v", 32'(if3.y_valid), 32'h1);
      end else begin
        check("l3_stream_idle_v", 32'(if3.y_valid), 32'h0);
      end
    end

    // LATENCY=3: reset with two words in flight discards them
    if3.a = 4'h3; if3.a_valid = 1'b1;
    tick();
    if3.a = 4'hC;
    tick();
    rst3 = 1'b1; if3.a = 4'h0; if3.a_valid = 1'b0;
    tick();
    rst3 = 1'b0;
    check("l3_midrst_y", 32'(if3.y), 32'hF);
    check("l3_midrst_v", 32'(if3.y_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l3_flush_y", 32'(if3.y), 32'hF);
      check("l3_flush_v", 32'(if3.y_valid), 32'h0);
    end

    // LATENCY=2 stall: en=0 freezes pipe and ignores inputs
    ifs.a = 4'h6; ifs.a_valid = 1'b1;
    tick();
    ifs.en = 1'b0; ifs.a = 4'hF; ifs.a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_y", 32'(ifs.y), 32'hF);
      check("stall_v", 32'(ifs.y_valid), 32'h0);
    end
    ifs.en = 1'b1; ifs.a = 4'h0; ifs.a_valid = 1'b0;
    tick();
    check("stall_rel_y", 32'(ifs.y), 32'h9);
    check("stall_rel_v", 32'(ifs.y_valid), 32'h1);
    tick();
    check("stall_after_v", 32'(ifs.y_valid), 32'h0);
    check("stall_after_y", 32'(ifs.y), 32'hF);

`ifdef NOT_GATE_TOGGLE_CNT_EN
    // Toggle counter: LATENCY=1, WIDTH=1
    rstt = 1'b1;
    tick();
    rstt = 1'b0;
    check("tc_rst", 32'(tct), 32'h0);
    for (int i = 0; i < 5; i++) begin
      ift.a = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
    end
    check("tc_five", 32'(tct), 32'h5);
    ift.a = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("tc_hold", 32'(tct), 32'h5);
    rstt = 1'b1;
    tick();
    rstt = 1'b0;
    check("tc_clear", 32'(tct), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
